piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out converter: the transmit-side counterpart to the parallel-capture register bank.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clk, with no gaps between words.
- Has one holding buffer, so the next word can be accepted while the current word is shifting.
- Serial side has no backpressure; downstream samples sout whenever sout_valid=1.

Parameters:
- WIDTH, 8, word width in bits (>=2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word; transfer occurs when din_valid & din_ready at a rising edge.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit this cycle.
- sout_last  output  1  sout carries the final bit of a word.
- busy  output  1  a word is shifting or buffered.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset state: shift register=0, bit_cnt=0, active=0, hold=0, hold_full=0.
  - Outputs during and after reset: sout=0, sout_valid=0, sout_last=0, busy=0, din_ready=1.
  - Asserting rst_n mid-word discards both the word in flight and the buffered word, with no partial completion.
- State: flag active (IDLE when 0, SHIFT when 1); shreg[WIDTH-1:0]; bit_cnt[$clog2(WIDTH)-1:0]; hold[WIDTH-1:0]; hold_full.
- Combinational outputs:
  - din_ready = !hold_full.
  - sout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0], gated to 0 when !active.
  - sout_valid = active.
  - sout_last = active & (bit_cnt==WIDTH-1).
  - busy = active | hold_full.
- IDLE: hold_full is always 0 here (invariant). On accept: shreg<=din, bit_cnt<=0, active<=1.
- Latency: a word accepted at edge N drives its first bit from edge N until edge N+1. Its last bit is driven in cycle N+WIDTH-1.
- SHIFT, bit not last: shreg shifts toward the output end and fills with 0; bit_cnt increments. An accept in this cycle writes hold<=din and hold_full<=1.
- SHIFT, last bit (sout_last=1), one of three cases:
  - hold_full=1: shreg<=hold, bit_cnt<=0, hold_full<=0, active stays 1. No accept is possible because din_ready=0.
  - hold_full=0 and an accept occurs: bypass, so shreg<=din, bit_cnt<=0, active stays 1.
  - hold_full=0 and no accept: active<=0 (return to IDLE).
- Throughput: back-to-back words produce a contiguous sout_valid stream, one word per WIDTH cycles, with no idle bit between words.
- Ordering: words leave in acceptance order. At most 2 words are held at any time.
- din is sampled only on an accepting edge; changes on din at other times have no effect.
- din_valid may drop without completing a transfer; nothing is accepted.

Test Plan:
- Reset, then pulse din=0xA5 for one accept (MSB_FIRST=1) -> sout 1,0,1,0,0,1,0,1 in the 8 following cycles; sout_valid=1 for exactly 8 cycles; sout_last=1 only on the 8th; busy falls after it.
- Hold din_valid=1 with words 0x3C, 0xFF, 0x01 -> 24 contiguous valid bits in order; din_ready=0 while hold_full=1; sout_last pulses every 8 cycles.
- Accept 0x81 while idle, then offer 0x55 exactly on the last-bit cycle with hold empty -> bypass load; second word starts the next cycle with no gap, and hold_full never asserts.
- MSB_FIRST=0, WIDTH=4, din=4'b0011 -> sout 1,1,0,0; sout_last on the 4th bit.
- Accept 0xF0 and a buffered 0x0F, then assert rst_n=0 at bit 3 -> all outputs zero immediately (asynchronously), din_ready=1. After release, 0xAA shifts out cleanly with no residue from 0x0F.
- Toggle din_valid with din_ready=0 and change din while not accepting -> the transmitted sequence reflects only the accepted words.

Source files
------------

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel word handshake in, serial bit stream out.
// Signals: din/din_valid/din_ready (word side), sout/sout_valid/sout_last/busy.
interface piso_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  sout_last,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output sout_last,
    output busy
  );

endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: WIDTH-bit words in over valid/ready, one bit per clk out.
// Ports: clk, rst_n (async active-low), bus (slave modport of piso_serializer_if).
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input logic              clk,
  input logic              rst_n,
  piso_serializer_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] hold_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             full_q;
  logic             full_d;

  logic             active;
  logic             is_last;
  logic             accept;
  logic             out_bit;
  logic [WIDTH-1:0] shifted;

  assign active  = (state_q == SHIFT);
  assign is_last = active && (cnt_q == LAST);
  assign accept  = bus.din_valid && !full_q;

  // Shift toward whichever end feeds sout, zero fill.
  assign shifted = (MSB_FIRST != 0)
                 ? {shreg_q[WIDTH-2:0], 1'b0}
                 : {1'b0, shreg_q[WIDTH-1:1]};

  assign out_bit = (MSB_FIRST != 0)
                 ? shreg_q[WIDTH-1]
                 : shreg_q[0];

  assign bus.din_ready  = !full_q;
  assign bus.sout       = active && out_bit;
  assign bus.sout_valid = active;
  assign bus.sout_last  = is_last;
  assign bus.busy       = active || full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        unique case (1'b1)
          !is_last: begin
            shreg_d = shifted;
            cnt_d   = cnt_q + 1'b1;
            if (accept) begin
              hold_d = bus.din;
              full_d = 1'b1;
            end
          end
          is_last && full_q: begin
            shreg_d = hold_q;
            cnt_d   = '0;
            full_d  = 1'b0;
          end
          // Empty buffer: a word offered now goes
          // straight into the shifter, no gap bit.
          is_last && !full_q && accept: begin
            shreg_d = bus.din;
            cnt_d   = '0;
          end
          default: begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  a_full_implies_active: assert property (
    @(posedge clk) disable iff (!rst_n)
    full_q |-> active
  );

  a_no_accept_when_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    full_q |-> !accept
  );

  a_cnt_in_range: assert property (
    @(posedge clk) disable iff (!rst_n)
    cnt_q <= LAST
  );

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: queue-model checks plus directed vectors
// for an 8-bit MSB-first and a 4-bit LSB-first serializer.
module tb_piso_serializer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  piso_serializer_if #(.WIDTH(8)) if8 ();
  piso_serializer_if #(.WIDTH(4)) if4 ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: every accepted word appends its bits, in send
  // order, to a queue; each clock the head bit is consumed.
  bit q8[$];
  bit l8[$];
  bit q4[$];
  bit l4[$];
  bit acc8;
  bit acc4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q8.delete();
      l8.delete();
    end else begin
      acc8 = if8.din_valid && (q8.size() <= 8);
      if (q8.size() > 0) begin
        void'(q8.pop_front());
        void'(l8.pop_front());
      end
      if (acc8)
        for (int i = 0; i < 8; i++) begin
          q8.push_back(if8.din[7-i]);
          l8.push_back(i == 7);
        end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q4.delete();
      l4.delete();
    end else begin
      acc4 = if4.din_valid && (q4.size() <= 4);
      if (q4.size() > 0) begin
        void'(q4.pop_front());
        void'(l4.pop_front());
      end
      if (acc4)
        for (int i = 0; i < 4; i++) begin
          q4.push_back(if4.din[i]);
          l4.push_back(i == 3);
        end
    end
  end

  always @(negedge clk) begin
    chk("valid8", if8.sout_valid, q8.size() > 0);
    chk("busy8", if8.busy, q8.size() > 0);
    chk("ready8", if8.din_ready, q8.size() <= 8);
    if (q8.size() > 0) begin
      chk("sout8", if8.sout, q8[0]);
      chk("last8", if8.sout_last, l8[0]);
    end else begin
      chk("sout8_idle", if8.sout, 0);
      chk("last8_idle", if8.sout_last, 0);
    end
    chk("valid4", if4.sout_valid, q4.size() > 0);
    chk("busy4", if4.busy, q4.size() > 0);
    chk("ready4", if4.din_ready, q4.size() <= 4);
    if (q4.size() > 0) begin
      chk("sout4", if4.sout, q4[0]);
      chk("last4", if4.sout_last, l4[0]);
    end
  end

  // Capture of the serial streams for the literal checks.
  logic [63:0] cap8;
  int          n8;
  int          nlast8;
  int          lastidx8;
  int          rdylow8;
  logic [63:0] cap4;
  int          n4;
  int          lastidx4;

  initial begin
    cap8 = '0; n8 = 0; nlast8 = 0;
    lastidx8 = -1; rdylow8 = 0;
    cap4 = '0; n4 = 0; lastidx4 = -1;
  end

  always @(negedge clk) begin
    if (rst_n && !if8.din_ready) rdylow8++;
    if (if8.sout_valid) begin
      if (if8.sout_last) begin
        nlast8++;
        lastidx8 = n8;
      end
      cap8 = {cap8[62:0], if8.sout};
      n8++;
    end
    if (if4.sout_valid) begin
      if (if4.sout_last) lastidx4 = n4;
      cap4 = {cap4[62:0], if4.sout};
      n4++;
    end
  end

  int s_n;
  int s_last;
  int s_rdy;

  task automatic snap();
    s_n    = n8;
    s_last = nlast8;
    s_rdy  = rdylow8;
  endtask

  function automatic logic [63:0] got8();
    int k;
    k = n8 - s_n;
    if (k >= 64) return cap8;
    return cap8 & ((64'd1 << k) - 64'd1);
  endfunction

  // Called just after a rising edge; returns just after
  // the accepting edge.
  task automatic send8(input logic [7:0] w);
    bit done;
    done = 0;
    if8.din       = w;
    if8.din_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = if8.din_ready;
      @(posedge clk);
      #1;
    end
    if8.din_valid = 1'b0;
    if (!done) chk("send8_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      idle = !if8.busy && !if4.busy;
    end
    chk("idle_timeout", idle, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    if8.din = '0;
    if8.din_valid = 1'b0;
    if4.din = '0;
    if4.din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sout", if8.sout, 0);
    chk("rst_valid", if8.sout_valid, 0);
    chk("rst_last", if8.sout_last, 0);
    chk("rst_busy", if8.busy, 0);
    chk("rst_ready", if8.din_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, MSB first.
    snap();
    send8(8'hA5);
    wait_idle();
    chk("a5_bits", n8 - s_n, 8);
    chk("a5_data", got8(), 64'hA5);
    chk("a5_lastcnt", nlast8 - s_last, 1);
    chk("a5_lastpos", lastidx8 - s_n, 7);

    // Streaming with buffer backpressure.
    snap();
    send8(8'h3C);
    send8(8'hFF);
    send8(8'h01);
    wait_idle();
    chk("str_bits", n8 - s_n, 24);
    chk("str_data", got8(), 64'h3CFF01);
    chk("str_lastcnt", nlast8 - s_last, 3);
    chk("str_rdylow", rdylow8 - s_rdy, 14);

    // Bypass on the last-bit cycle.
    snap();
    send8(8'h81);
    repeat (7) @(posedge clk);
    #1;
    chk("byp_at_last", if8.sout_last, 1);
    send8(8'h55);
    wait_idle();
    chk("byp_bits", n8 - s_n, 16);
    chk("byp_data", got8(), 64'h8155);
    chk("byp_rdylow", rdylow8 - s_rdy, 0);

    // LSB first, 4 bits.
    if4.din       = 4'b0011;
    if4.din_valid = 1'b1;
    @(posedge clk);
    #1;
    if4.din_valid = 1'b0;
    if4.din       = 4'b1111;
    wait_idle();
    chk("w4_bits", n4, 4);
    chk("w4_data", cap4[3:0], 4'b1100);
    chk("w4_lastpos", lastidx4, 3);

    // Reset in the middle of a word with one buffered.
    send8(8'hF0);
    send8(8'h0F);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_sout", if8.sout, 0);
    chk("mrst_valid", if8.sout_valid, 0);
    chk("mrst_last", if8.sout_last, 0);
    chk("mrst_busy", if8.busy, 0);
    chk("mrst_ready", if8.din_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    snap();
    send8(8'hAA);
    wait_idle();
    chk("post_bits", n8 - s_n, 8);
    chk("post_data", got8(), 64'hAA);

    // Ignored offers while full, din noise while idle.
    snap();
    send8(8'h11);
    send8(8'h22);
    for (int i = 0; i < 4; i++) begin
      if8.din       = 8'hE0 + 8'(i);
      if8.din_valid = (i % 2) == 0;
      @(posedge clk);
      #1;
    end
    if8.din_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if8.din = 8'(i * 37);
      @(posedge clk);
      #1;
    end
    wait_idle();
    chk("ign_bits", n8 - s_n, 16);
    chk("ign_data", got8(), 64'h1122);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
